// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_frame_tx
// Description : Serial frame transmitter for the 1011-sync serial bit link.
//               Accepts a parallel payload over valid/ready and emits, one bit
//               per clock: sync header (MSB first), payload (MSB first),
//               optional even-parity bit, then GAP_BITS idle zeros.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous reset, active-low
//               in_data    - payload word (DATA_W bits)
//               in_valid   - in_data is valid
//               in_ready   - block can accept a payload this cycle
//               out_bit    - registered serial line
//               tx_active  - high while sync/payload/parity bits are driven
//               frame_done - one-cycle pulse with the final frame bit
// Revision    : 1.0 - initial release
// ============================================================================
module seq_frame_tx #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC      = 4'b1011,
  parameter int                PARITY_EN = 0,
  parameter int                GAP_BITS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              tx_active,
  output logic              frame_done
);

  // Counter sized for the longest state; it counts down to zero so that the
  // value doubles as the sync bit index.
  localparam int C_MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int C_MAX_N  = (C_MAX_SD > GAP_BITS) ? C_MAX_SD : GAP_BITS;
  localparam int C_CNT_W  = $clog2(C_MAX_N) + 1;

  localparam logic [C_CNT_W-1:0] C_SYNC_LAST = C_CNT_W'(SYNC_W - 1);
  localparam logic [C_CNT_W-1:0] C_DATA_LAST = C_CNT_W'(DATA_W - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LAST  = C_CNT_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
  localparam logic [C_CNT_W-1:0] C_ONE       = C_CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // The state that carries the last bit of a frame, given which optional
  // states are present.
  localparam state_t C_LAST_ST = (GAP_BITS > 0)  ? ST_GAP :
                                 (PARITY_EN != 0) ? ST_PAR : ST_DATA;

  state_t              state_q, state_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_q, par_d;
  logic                out_bit_q, out_bit_d;
  logic                tx_active_q, tx_active_d;
  logic                frame_done_q, frame_done_d;

  logic [C_CNT_W-1:0]  cnt_dec;
  logic [SYNC_W-1:0]   sync_sh;

  assign cnt_dec = cnt_q - C_ONE;
  // Sync bit for the next counter value, picked out by shifting the pattern.
  assign sync_sh = SYNC >> cnt_dec;

  assign in_ready   = (state_q == ST_IDLE) && reset;
  assign out_bit    = out_bit_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;

  // Next-state logic. out_bit_d is the bit that will be on the line during
  // the state being entered, so the registered output lines up with state_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    out_bit_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_SYNC;
          cnt_d     = C_SYNC_LAST;
          out_bit_d = SYNC[SYNC_W-1];
          shreg_d   = in_data;
          par_d     = ^in_data;
        end
      end

      ST_SYNC: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_dec;
          out_bit_d = sync_sh[0];
        end else begin
          state_d   = ST_DATA;
          cnt_d     = C_DATA_LAST;
          out_bit_d = shreg_q[DATA_W-1];
          shreg_d   = shreg_q << 1;
        end
      end

      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_dec;
          out_bit_d = shreg_q[DATA_W-1];
          shreg_d   = shreg_q << 1;
        end else if (PARITY_EN != 0) begin
          state_d   = ST_PAR;
          cnt_d     = '0;
          out_bit_d = par_q;
        end else if (GAP_BITS > 0) begin
          state_d   = ST_GAP;
          cnt_d     = C_GAP_LAST;
        end else begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end
      end

      ST_PAR: begin
        if (GAP_BITS > 0) begin
          state_d = ST_GAP;
          cnt_d   = C_GAP_LAST;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign tx_active_d  = (state_d == ST_SYNC) || (state_d == ST_DATA) || (state_d == ST_PAR);
  assign frame_done_d = (state_d == C_LAST_ST) && (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      out_bit_q    <= 1'b0;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      out_bit_q    <= out_bit_d;
      tx_active_q  <= tx_active_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_frame_tx
// Description : Scoreboard bench for seq_frame_tx. Three instances cover the
//               default configuration, parity enabled, and no gap bits. One
//               instance is selected at a time; its expected line values are
//               queued at accept and popped every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_frame_tx;

  typedef struct packed {
    logic b;
    logic a;
    logic d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'hA5;
  logic       vld = 1'b1;
  int         sel = 0;

  logic [2:0] vlds, rdy, ob, ta, fd;

  exp_t q[$];
  int   m_busy = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  assign vlds[0] = vld && (sel == 0);
  assign vlds[1] = vld && (sel == 1);
  assign vlds[2] = vld && (sel == 2);

  seq_frame_tx u_dut_def (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vlds[0]),
    .in_ready(rdy[0]), .out_bit(ob[0]), .tx_active(ta[0]), .frame_done(fd[0])
  );

  seq_frame_tx #(.PARITY_EN(1)) u_dut_par (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vlds[1]),
    .in_ready(rdy[1]), .out_bit(ob[1]), .tx_active(ta[1]), .frame_done(fd[1])
  );

  seq_frame_tx #(.GAP_BITS(0)) u_dut_nogap (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vlds[2]),
    .in_ready(rdy[2]), .out_bit(ob[2]), .tx_active(ta[2]), .frame_done(fd[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  // Queue the complete expected frame for configuration s.
  task automatic push_frame(input int s, input logic [7:0] d);
    exp_t       e;
    logic [3:0] sync_pat;
    int         pe, gap;
    sync_pat = 4'b1011;
    pe  = (s == 1) ? 1 : 0;
    gap = (s == 2) ? 0 : 2;
    for (int i = 3; i >= 0; i--) q.push_back('{b: sync_pat[i], a: 1'b1, d: 1'b0});
    for (int i = 7; i >= 0; i--) q.push_back('{b: d[i], a: 1'b1, d: 1'b0});
    if (pe != 0) q.push_back('{b: ^d, a: 1'b1, d: 1'b0});
    for (int i = 0; i < gap; i++) q.push_back('{b: 1'b0, a: 1'b0, d: 1'b0});
    e = q[q.size()-1];
    e.d = 1'b1;
    q[q.size()-1] = e;
    m_busy = 12 + pe + gap;
  endtask

  // Reference model and per-cycle comparison of the selected instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_busy = 0;
        q.delete();
      end else if (m_busy > 0) begin
        m_busy--;
      end else if (vld) begin
        push_frame(sel, in_data);
      end
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front();
      else              e = '0;
      check("out_bit",    32'(ob[sel]), 32'(e.b));
      check("tx_active",  32'(ta[sel]), 32'(e.a));
      check("frame_done", 32'(fd[sel]), 32'(e.d));
      check("in_ready",   32'(rdy[sel]), 32'((m_busy == 0) && reset));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && m_busy != 0; i++) @(negedge clk);
    check("idle_wait", 32'(m_busy == 0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1;
    vld = 1'b1;
    in_data = d;
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with in_valid high; A5 is accepted right after release.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
    wait_idle();

    // Parity configuration: odd and even payload weights.
    sel = 1;
    send(8'h07);
    wait_idle();
    send(8'h03);
    wait_idle();

    // Continuous valid; payload changes mid-frame must not leak in.
    sel = 0;
    in_data = 8'hFF;
    vld = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    in_data = 8'h81;
    repeat (25) @(posedge clk);
    #1;
    vld = 1'b0;
    wait_idle();

    // Payload containing the sync pattern goes out verbatim.
    send(8'hB2);
    wait_idle();

    // Reset during the 3rd data bit aborts the frame.
    send(8'h5A);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(8'h3C);
    wait_idle();

    // No gap bits: frame_done on the last data bit.
    sel = 2;
    send(8'h00);
    wait_idle();
    send(8'hC9);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
